core_clock_sequencer: RTL
=========================

CORE_CLOCK_SEQUENCER -- requirements
Module: core_clock_sequencer

Interface
REQ-001 Parameter RST_CYCLES, default 4: clk cycles core_rst stays asserted after Reset deasserts; must be at least 1.
REQ-002 Parameter DIV_W, default 8: width of div.
REQ-003 Parameter BURST_W, default 8: width of burst_len.
REQ-004 Parameter CNT_W, default 16: width of cycle_count.
REQ-005 Parameter DEB_CYCLES, default 16: debounce stability window; used only when STEP_DEBOUNCE_EN is defined.
REQ-006 clk  input  1  single system clock; all state updates on its rising edge.
REQ-007 Reset  input  1  synchronous, active-high reset.
REQ-008 mode  input  2  00 free-run, 01 divided, 10 single-step, 11 burst.
REQ-009 div  input  DIV_W  divide ratio; the core advances once every div+1 cycles.
REQ-010 burst_len  input  BURST_W  number of core_ce pulses per burst; 0 is treated as 1.
REQ-011 step  input  1  asynchronous step button; level-sensitive, raw.
REQ-012 halt  input  1  freezes core advancement while high.
REQ-013 core_rst  output  1  registered synchronous active-high reset to the datapath.
REQ-014 core_ce  output  1  registered single-cycle core clock enable.
REQ-015 busy  output  1  registered; high while in RUN with halt low.
REQ-016 cycle_count  output  CNT_W  registered count of core_ce pulses issued.

Function
REQ-017 FSM states: HOLD, WAIT, RUN.
REQ-018 HOLD: core_rst=1 and core_ce=0; after RST_CYCLES cycles with Reset low, go to RUN for modes 00/01, or to WAIT for modes 10/11.
REQ-019 Mode 00 in RUN: core_ce=1 every cycle while halt=0.
REQ-020 Mode 01 in RUN: divider counter counts 0..div; core_ce=1 in the cycle the counter reaches >=div, and the counter then clears; div=0 is equivalent to mode 00.
REQ-021 Step edge detection: step passes through a 2-flop synchronizer plus an edge register; a rising edge is accepted only in WAIT with halt=0.
REQ-022 Mode 10: an accepted edge yields exactly one core_ce pulse, with FSM staying in WAIT.
REQ-023 Mode 10 latency: step first sampled high at edge k gives core_ce high in the cycle after edge k+3 (debounce macro absent).
REQ-024 Mode 11: an accepted edge loads the remaining count with max(burst_len,1) and goes to RUN.
REQ-025 Mode 11 RUN: one core_ce per cycle, decrementing the count; after the last pulse, return to WAIT; step edges during RUN are ignored.
REQ-026 halt=1 forces core_ce=0 in every state and freezes the divider counter and the burst remaining count.
REQ-027 Releasing halt resumes from the frozen values.
REQ-028 A mode change is detected by a registered compare; the next cycle aborts any burst and clears the divider.
REQ-029 After a mode change, the FSM goes to RUN (00/01) or WAIT (10/11); it does not re-enter HOLD.
REQ-030 cycle_count increments by 1 on each core_ce pulse and wraps from all-ones to 0.
REQ-031 A simultaneous mode change and accepted step edge: the mode change wins and the edge is discarded.

Reset
REQ-032 Reset=1 at a rising edge forces HOLD, core_rst=1, core_ce=0 and busy=0.
REQ-033 Reset=1 at a rising edge clears cycle_count, the divider, the burst count, the synchronizer and the debounce state.
REQ-034 Reset mid-burst or mid-divide aborts the operation immediately; the HOLD count restarts from 0 when Reset falls.
REQ-035 Reset held for several cycles keeps core_rst=1 throughout.

Configuration
REQ-036 Macro STEP_DEBOUNCE_EN defined: the synchronized step must be stable for DEB_CYCLES consecutive cycles before its new level is accepted, and edge latency grows by DEB_CYCLES.
REQ-037 Macro STEP_DEBOUNCE_EN absent: no debounce filter; latency is per REQ-023.

Verification
REQ-038 Reset high 3 cycles, then low, mode=00 -> core_rst high until 4 cycles after the Reset fall; then core_ce high every cycle; cycle_count=10 after 10 pulses.
REQ-039 mode=01, div=3 -> core_ce high exactly 1 cycle in 4; 5 pulses in 20 cycles.
REQ-040 mode=10, step high 50 cycles -> exactly one core_ce, 4 cycles after step rises; cycle_count +1.
REQ-041 mode=11, burst_len=5, step pulse, halt high 3 cycles after the 2nd pulse -> 5 pulses total, with a 3-cycle gap; step edges during the burst are ignored.
REQ-042 mode=00, CNT_W=4, run 17 pulses -> cycle_count wraps to 1; Reset asserted mid-run -> cycle_count=0, core_rst=1 next cycle.
REQ-043 STEP_DEBOUNCE_EN, DEB_CYCLES=16, step toggling every 5 cycles, then stable high -> no pulse while toggling; one pulse after stable high plus 16+4 cycles.

Source files
------------

// File: rtl/core_clock_sequencer.sv
// core_clock_sequencer: reset/clock-enable sequencer for a stepped core datapath.
// The optional step debounce filter is compiled in when STEP_DEBOUNCE_EN is defined.
module core_clock_sequencer #(
  parameter int RST_CYCLES = 4,
  parameter int DIV_W      = 8,
  parameter int BURST_W    = 8,
  parameter int CNT_W      = 16,
  parameter int DEB_CYCLES = 16
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic [1:0]         mode,
  input  logic [DIV_W-1:0]   div,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               step,
  input  logic               halt,
  output logic               core_rst,
  output logic               core_ce,
  output logic               busy,
  output logic [CNT_W-1:0]   cycle_count
);
  localparam int HW = $clog2(RST_CYCLES + 1);
  typedef enum logic [1:0] {HOLD, WAIT, RUN} state_t;
  if (RST_CYCLES < 1 || DEB_CYCLES < 1) begin : g_bad_cfg
    $error("core_clock_sequencer: RST_CYCLES and DEB_CYCLES must be at least 1");
  end
  state_t             r_state;
  logic [HW-1:0]      r_hcnt;
  logic [DIV_W-1:0]   r_div;
  logic [BURST_W-1:0] r_rem;
  logic [1:0]         r_mode_q;
  logic [1:0]         r_sync;
  logic               r_prev;
  logic               r_edge;
  logic               r_rst;
  logic               r_ce;
  logic               r_busy;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_lvl;
  logic               w_mchg;
  logic               w_acc;
  logic               w_fire;
  // Synchronize the raw step button and register its rising edge
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_edge <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], step};
      r_prev <= w_lvl;
      r_edge <= w_lvl & ~r_prev;
    end
  end
`ifdef STEP_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES + 1);
  logic [DW-1:0] r_deb_cnt;
  logic          r_deb;
  // Accept a new step level only after it has been stable for DEB_CYCLES cycles
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_deb_cnt <= '0;
      r_deb     <= 1'b0;
    end else if (r_sync[1] == r_deb) begin
      r_deb_cnt <= '0;
    end else if (r_deb_cnt == DW'(DEB_CYCLES - 1)) begin
      r_deb_cnt <= '0;
      r_deb     <= r_sync[1];
    end else begin
      r_deb_cnt <= r_deb_cnt + 1'b1;
    end
  end
  assign w_lvl = r_deb;
`else
  assign w_lvl = r_sync[1];
`endif
  assign w_mchg = r_mode_q != mode;
  assign w_acc  = r_state == WAIT && r_edge && !halt && !w_mchg;
  assign w_fire = !Reset && !halt && !w_mchg &&
                  ((r_state == RUN && (mode != 2'd1 || r_div >= div)) || (w_acc && mode == 2'd2));
  // Sequencer FSM with registered reset, enable, busy and pulse count
  always_ff @(posedge clk) begin
    r_ce  <= w_fire;
    r_cnt <= r_cnt + CNT_W'(w_fire);
    if (Reset) begin
      r_state  <= HOLD;
      r_hcnt   <= '0;
      r_div    <= '0;
      r_rem    <= '0;
      r_mode_q <= mode;
      r_rst    <= 1'b1;
      r_busy   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_mode_q <= mode;
      if (r_state == HOLD) begin
        r_busy <= 1'b0;
        if (r_hcnt == HW'(RST_CYCLES - 1)) begin
          r_rst   <= 1'b0;
          r_state <= mode[1] ? WAIT : RUN;
          r_busy  <= !mode[1] && !halt;
        end else begin
          r_hcnt <= r_hcnt + 1'b1;
        end
      end else if (w_mchg) begin
        r_state <= mode[1] ? WAIT : RUN;
        r_div   <= '0;
        r_rem   <= '0;
        r_busy  <= !mode[1] && !halt;
      end else if (r_state == WAIT) begin
        r_busy <= 1'b0;
        if (w_acc && mode == 2'd3) begin
          r_rem   <= burst_len == '0 ? BURST_W'(1) : burst_len;
          r_state <= RUN;
          r_busy  <= 1'b1;
        end
      end else begin
        r_busy <= !halt && !(mode == 2'd3 && r_rem == BURST_W'(1));
        if (!halt && mode == 2'd1) r_div <= r_div >= div ? '0 : r_div + 1'b1;
        if (!halt && mode == 2'd3) begin
          r_rem <= r_rem - 1'b1;
          if (r_rem == BURST_W'(1)) r_state <= WAIT;
        end
      end
    end
  end
  assign core_rst    = r_rst;
  assign core_ce     = r_ce;
  assign busy        = r_busy;
  assign cycle_count = r_cnt;
endmodule
